rom_sequencer: RTL and testbench

- Parametrised successor to the free-running ROM fetcher.
- Walks a synchronous ROM (1-cycle read latency) between programmable loop bounds and presents each word on `q` with a `q_valid` strobe.
- Three modes: free-run loop, one-shot and single-step. Start/stop control.
- Built-in tick prescaler replaces the separate slow-clock divider, so the block runs on the main clock domain. It feeds `hex_display` or any other consumer of ROM data.

---
 rtl/rom_sequencer.sv | 144 ++++++++++++++
 tb/tb_rom_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sequencer.sv
// Walks a synchronous ROM between latched loop bounds: free-run, one-shot or single-step, with a built-in tick prescaler.
// Optional macro ROM_SEQ_DIR_EN adds a `dir` input that lets the walk run downward.
module rom_sequencer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIV_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic              step,
`ifdef ROM_SEQ_DIR_EN
    input  logic              dir,
`endif
    input  logic [DIV_W-1:0]  div_max,
    input  logic [ADDR_W-1:0] loop_start,
    input  logic [ADDR_W-1:0] loop_end,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] lp_start;
    logic [ADDR_W-1:0] lp_end;
    logic [1:0]        mode_l;
    logic [DIV_W-1:0]  cnt;
    logic [DATA_W-1:0] rom_hold;
    logic              cap_pend;
`ifdef ROM_SEQ_DIR_EN
    logic              dir_l;
`endif

    logic              down_c;
    logic              at_end_c;
    logic              one_shot_c;
    logic              step_mode_c;
    logic              advance_c;
    logic [ADDR_W-1:0] pc_step_c;

    // Walk direction and advance decision for the current WAIT cycle
`ifdef ROM_SEQ_DIR_EN
    assign down_c = dir_l;
`else
    assign down_c = 1'b0;
`endif
    assign at_end_c    = (pc == lp_end);
    assign one_shot_c  = mode_l[0];
    assign step_mode_c = (mode_l == 2'b10);
    assign pc_step_c   = down_c ? (pc - ADDR_W'(1)) : (pc + ADDR_W'(1));
    // The first WAIT cycle publishes the flopped ROM word, so advancing starts after it
    assign advance_c   = (state == ST_WAIT) && !cap_pend &&
                         (step_mode_c ? step : (cnt >= div_max));

    assign rom_addr = pc;

    // Sequencer FSM with registered outputs; priority stop > start > advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            lp_start <= '0;
            lp_end   <= '0;
            mode_l   <= 2'b00;
            cnt      <= '0;
            rom_hold <= '0;
            cap_pend <= 1'b0;
            q        <= '0;
            q_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef ROM_SEQ_DIR_EN
            dir_l    <= 1'b0;
`endif
        end else begin
            q_valid <= 1'b0;
            done    <= 1'b0;
            if (stop) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                cap_pend <= 1'b0;
            end else if (start) begin
                mode_l   <= mode;
                lp_start <= loop_start;
                lp_end   <= loop_end;
`ifdef ROM_SEQ_DIR_EN
                dir_l    <= dir;
`endif
                pc       <= loop_start;
                cnt      <= '0;
                cap_pend <= 1'b0;
                busy     <= 1'b1;
                state    <= ST_ISSUE;
            end else begin
                case (state)
                    ST_ISSUE: begin
                        state <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        rom_hold <= rom_q;
                        cap_pend <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (cap_pend) begin
                            q        <= rom_hold;
                            q_valid  <= 1'b1;
                            cap_pend <= 1'b0;
                        end else if (advance_c) begin
                            cnt <= '0;
                            if (at_end_c && one_shot_c) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                pc    <= at_end_c ? lp_start : pc_step_c;
                                state <= ST_ISSUE;
                            end
                        end else if (!step_mode_c) begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer: an event-level model predicts every output per clock edge.
module tb_rom_sequencer;

    localparam int MAXE = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [23:0] div_max = '0;
    logic [7:0]  loop_start = '0;
    logic [7:0]  loop_end = '0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_q = '0;
    logic [15:0] q;
    logic        q_valid;
    logic        busy;
    logic        done;
`ifdef ROM_SEQ_DIR_EN
    logic        dir = 1'b0;
`endif

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int exp_qv[MAXE];
    int exp_q[MAXE];
    int exp_done[MAXE];
    int exp_busy[MAXE];
    int exp_ad[MAXE];
    bit step_at[MAXE];

    rom_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .step       (step),
`ifdef ROM_SEQ_DIR_EN
        .dir        (dir),
`endif
        .div_max    (div_max),
        .loop_start (loop_start),
        .loop_end   (loop_end),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .q          (q),
        .q_valid    (q_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ROM image: word i holds 0x1000 + i, one cycle read latency
    always @(posedge clk) rom_q <= 16'h1000 + 16'(rom_addr);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) step = (cyc + 1 < MAXE) ? step_at[cyc + 1] : 1'b0;

    task automatic chk(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, want);
        end
    endtask

    // Outputs are stable mid-cycle; exp_*[k] describes them after clock edge k
    always @(negedge clk) begin
        if (cyc < MAXE) begin
            chk("q_valid", int'(q_valid), exp_qv[cyc]);
            chk("q", int'(q), exp_q[cyc]);
            chk("done", int'(done), exp_done[cyc]);
            chk("busy", int'(busy), exp_busy[cyc]);
            chk("rom_addr", int'(rom_addr), exp_ad[cyc]);
        end
    end

    // Block goes idle from edge c on with q and address frozen
    function automatic void plan_stop(input int c);
        for (int i = c; i < MAXE; i++) begin
            exp_qv[i]   = 0;
            exp_done[i] = 0;
            exp_busy[i] = 0;
            exp_q[i]    = exp_q[c - 1];
            exp_ad[i]   = exp_ad[c - 1];
        end
    endfunction

    function automatic void plan_zero(input int c);
        for (int i = c; i < MAXE; i++) begin
            exp_qv[i]   = 0;
            exp_done[i] = 0;
            exp_busy[i] = 0;
            exp_q[i]    = 0;
            exp_ad[i]   = 0;
        end
    endfunction

    // A run started at edge s: each fetch decision yields q_valid three edges later
    function automatic void plan_run(input int s, input int md, input int ls, input int le,
                                     input int dm, input int dr);
        int d;
        int len;
        int k;
        int f;
        int a;
        int qe;
        int e;
        bit one;
        bit stp;
        bit run;
        d   = (dr != 0) ? -1 : 1;
        len = ((((le - ls) * d) % 256) + 256) % 256 + 1;
        one = (md == 1) || (md == 3);
        stp = (md == 2);
        for (int i = s; i < MAXE; i++) begin
            exp_qv[i]   = 0;
            exp_done[i] = 0;
            exp_busy[i] = 1;
            exp_q[i]    = -1;
            exp_ad[i]   = -1;
        end
        exp_ad[s] = ls;
        k   = 0;
        f   = s;
        a   = ls;
        run = 1'b1;
        while (run) begin
            qe = f + 3;
            if (qe >= MAXE) begin
                run = 1'b0;
            end else begin
                exp_qv[qe] = 1;
                exp_q[qe]  = 32'h1000 + a;
                if (stp) begin
                    e = qe + 1;
                    while (e < MAXE && !step_at[e]) e++;
                end else begin
                    e = qe + dm + 1;
                end
                if (e >= MAXE) begin
                    run = 1'b0;
                end else if (k == len - 1 && one) begin
                    exp_done[e] = 1;
                    for (int i = e; i < MAXE; i++) exp_busy[i] = 0;
                    run = 1'b0;
                end else begin
                    if (k == len - 1) begin
                        k = 0;
                        a = ls;
                    end else begin
                        k++;
                        a = (a + d + 256) % 256;
                    end
                    exp_ad[e] = a;
                    f = e;
                end
            end
        end
        for (int i = s; i < MAXE; i++) begin
            if (exp_q[i] < 0) exp_q[i] = exp_q[i - 1];
            if (exp_ad[i] < 0) exp_ad[i] = exp_ad[i - 1];
        end
    endfunction

    task automatic do_start(input int md, input int ls, input int le, input int dm,
                            input int dr, input bit kill, output int s);
        mode       = 2'(md);
        loop_start = 8'(ls);
        loop_end   = 8'(le);
        div_max    = 24'(dm);
`ifdef ROM_SEQ_DIR_EN
        dir        = dr[0];
`endif
        start = 1'b1;
        stop  = kill;
        s     = cyc + 1;
        if (kill) plan_stop(s);
        else plan_run(s, md, ls, le, dm, dr);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        plan_stop(cyc + 1);
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int sc;
        repeat (3) @(negedge clk);
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Free-run 2..4, div_max 0: four cycles per word
        do_start(0, 2, 4, 0, 0, 1'b0, s);
        wait_to(s + 3);  chk("freerun_first", int'(q), 32'h1002);
        chk("freerun_first_v", int'(q_valid), 1);
        wait_to(s + 7);  chk("freerun_w1", int'(q), 32'h1003);
        wait_to(s + 11); chk("freerun_w2", int'(q), 32'h1004);
        wait_to(s + 15); chk("freerun_wrap", int'(q), 32'h1002);
        wait_to(s + 17);

        // One-shot 5..6, div_max 3, started as a restart while busy
        do_start(1, 5, 6, 3, 0, 1'b0, s);
        wait_to(s + 3);  chk("oneshot_w0", int'(q), 32'h1005);
        wait_to(s + 10); chk("oneshot_w1_v", int'(q_valid), 1);
        chk("oneshot_w1", int'(q), 32'h1006);
        wait_to(s + 14); chk("oneshot_done", int'(done), 1);
        chk("oneshot_idle", int'(busy), 0);
        wait_to(s + 16);

        // Single-step 0..1: a step during ISSUE is dropped, three steps in WAIT advance
        sc = cyc + 1;
        step_at[sc + 1]  = 1'b1;
        step_at[sc + 6]  = 1'b1;
        step_at[sc + 12] = 1'b1;
        step_at[sc + 18] = 1'b1;
        do_start(2, 0, 1, 0, 0, 1'b0, s);
        wait_to(s + 3);  chk("step_first", int'(q), 32'h1000);
        wait_to(s + 8);  chk("step_hold_v", int'(q_valid), 0);
        wait_to(s + 9);  chk("step_1", int'(q), 32'h1001);
        wait_to(s + 15); chk("step_2", int'(q), 32'h1000);
        wait_to(s + 21); chk("step_3", int'(q), 32'h1001);
        wait_to(s + 24);

        // Stop sampled during CAPTURE: no q_valid, q keeps its previous word
        do_start(0, 10, 12, 2, 0, 1'b0, s);
        wait_to(s + 1);
        do_stop();
        wait_to(s + 3);  chk("stopcap_v", int'(q_valid), 0);
        chk("stopcap_q", int'(q), 32'h1001);
        wait_to(s + 6);

        // Reversed bounds 0xFE..0x01 in one-shot wrap through 0xFF
        do_start(1, 254, 1, 1, 0, 1'b0, s);
        wait_to(s + 8);  chk("rev_w1", int'(q), 32'h10FF);
        wait_to(s + 18); chk("rev_w3", int'(q), 32'h1001);
        wait_to(s + 20); chk("rev_done", int'(done), 1);
        wait_to(s + 22);

        // start together with stop in WAIT: stop wins
        do_start(0, 7, 7, 5, 0, 1'b0, s);
        wait_to(s + 3);  chk("same_word", int'(q), 32'h1007);
        wait_to(s + 4);
        begin
            int s2;
            do_start(1, 20, 30, 0, 0, 1'b1, s2);
        end
        wait_to(s + 5);  chk("startstop_busy", int'(busy), 0);
        wait_to(s + 8);  chk("startstop_v", int'(q_valid), 0);
        chk("startstop_q", int'(q), 32'h1007);
        wait_to(s + 10);

        // Asynchronous reset in the middle of WAIT
        do_start(0, 3, 4, 6, 0, 1'b0, s);
        wait_to(s + 5);
        #2;
        rst_n = 1'b0;
        plan_zero(cyc + 1);
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_addr", int'(rom_addr), 0);
        chk("arst_v", int'(q_valid), 0);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        wait_to(cyc + 3);

`ifdef ROM_SEQ_DIR_EN
        // Downward one-shot 3..1
        do_start(1, 3, 1, 0, 1, 1'b0, s);
        wait_to(s + 3);  chk("down_w0", int'(q), 32'h1003);
        wait_to(s + 7);  chk("down_w1", int'(q), 32'h1002);
        wait_to(s + 11); chk("down_w2", int'(q), 32'h1001);
        wait_to(s + 12); chk("down_done", int'(done), 1);
        wait_to(s + 14);
`endif

        wait_to(cyc + 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
